// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the multiplexed 7-segment display scheduler
package disp_pkg;
  typedef enum logic {BLANK, SHOW} estado_t;
  localparam int NUM_DIGITOS = 4;
  localparam logic [3:0] ANODO_OFF = 4'b1111;
  typedef logic [3:0] digito_t;
endpackage

// File: rtl/contador_ticks.sv
// contador_ticks: loadable up-counter with clear and terminal count against a runtime limit
module contador_ticks #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic         tc
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= count + W'(1);
  assign tc = count == limit;
endmodule

// File: rtl/secuenciador_display.sv
// secuenciador_display: round-robin 4-digit scan with dead-time blanking; LEADING_ZERO_BLANK_EN hides leading zeros
module secuenciador_display
  import disp_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000,
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digitos,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  anodo,
  output digito_t     digito,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);
  estado_t state, state_n;
  logic [1:0] sel_n;
  logic [NUM_DIGITOS*4-1:0] snap, snap_n;
  logic [NUM_DIGITOS-1:0] mask, mask_n, lz;
  logic [CNT_W-1:0] limit;
  logic tc;
  assign limit = state == BLANK ? CNT_W'(BLANK_TICKS - 1) : CNT_W'(DIGIT_TICKS - 1);
  contador_ticks #(.W(CNT_W)) u_cnt (
    .clk(clk), .reset(reset), .en(1'b1), .clr(!enable || tc),
    .load(1'b0), .load_val('0), .limit(limit), .tc(tc)
  );
`ifdef LEADING_ZERO_BLANK_EN
  assign lz = {digitos[15:12] == 4'h0, digitos[15:8] == 8'h0, digitos[15:4] == 12'h0, 1'b0};
`else
  assign lz = '0;
`endif
  always_comb begin
    state_n = state;
    sel_n = digit_sel;
    snap_n = snap;
    mask_n = mask;
    if (!enable) begin
      state_n = BLANK;
      sel_n = 2'd0;
    end else if (tc && state == BLANK) begin
      state_n = SHOW;
      snap_n = digit_sel == 2'd0 ? digitos : snap;
      mask_n = digit_sel == 2'd0 ? blank_mask | lz : mask;
    end else if (tc) begin
      state_n = BLANK;
      sel_n = digit_sel + 2'd1;
    end
  end
  // Outputs derive from next-state values so anodes and digit code switch together with the FSM
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= BLANK;
      digit_sel <= 2'd0;
      snap <= '0;
      mask <= '0;
      anodo <= ANODO_OFF;
      digito <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      digit_sel <= sel_n;
      snap <= snap_n;
      mask <= mask_n;
      anodo <= state_n == SHOW && !mask_n[sel_n] ? ~(4'b0001 << sel_n) : ANODO_OFF;
      digito <= state_n == SHOW ? snap_n[sel_n*4 +: 4] : digito;
      frame_done <= enable && tc && state == SHOW && digit_sel == 2'd3;
    end
endmodule

// File: tb/tb_secuenciador_display.sv
// tb_secuenciador_display: randomized scan check against a frame-position model; honours LEADING_ZERO_BLANK_EN
module tb_secuenciador_display;
  localparam int B = 2, D = 4, S = B + D, F = 4 * S;
  logic clk = 0, reset = 1, enable = 1;
  logic [15:0] digitos = 16'h4321;
  logic [3:0] blank_mask = 4'h0, anodo, digito;
  logic [1:0] digit_sel;
  logic frame_done;
  int checks = 0, errors = 0;
  int pos;
  logic [15:0] snap;
  logic [3:0] smask, last_dig;
  logic exp_fd;
  bit rst_pending;

  secuenciador_display #(.DIGIT_TICKS(D), .BLANK_TICKS(B), .CNT_W(17)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digitos(digitos), .blank_mask(blank_mask),
    .anodo(anodo), .digito(digito), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
    bit nz = 0;
    for (int i = 3; i >= 1; i--) begin
      nz = nz || (d[i*4 +: 4] != 4'h0);
      if (!nz) m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  task automatic model_reset();
    pos = 0; snap = '0; smask = '0; last_dig = '0; exp_fd = 0;
  endtask

  task automatic model_step();
    exp_fd = enable && pos == F - 1;
    pos = enable ? (pos + 1) % F : 0;
    if (enable && pos == B) begin
      snap = digitos;
      smask = blank_mask | lz_mask(digitos);
    end
    if (enable && pos % S == B) last_dig = snap[(pos / S) * 4 +: 4];
  endtask

  function automatic bit lit();
    return pos % S >= B;
  endfunction

  task automatic compare_all();
    int slot = pos / S;
    logic [3:0] exp_an = lit() && !smask[slot] ? ~(4'b0001 << slot) : 4'hF;
    check("anodo", anodo, exp_an);
    check("digit_sel", {2'b00, digit_sel}, 4'(slot));
    check("digito", digito, last_dig);
    check("frame_done", {3'b000, frame_done}, {3'b000, exp_fd});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1 compare_all();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    reset = 0;
    repeat (2 * F + 5) cycle();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 500) rst_pending = 1;
      if (rst_pending && lit()) begin
        rst_pending = 0;
        #2 reset = 1;
        #1 check("async_anodo", anodo, 4'hF);
        check("async_digito", digito, 4'h0);
        check("async_fd", {3'b000, frame_done}, 4'h0);
        @(posedge clk);
        #1 check("rst_hold_anodo", anodo, 4'hF);
        @(negedge clk);
        reset = 0;
        model_reset();
      end
      enable = $urandom_range(0, 39) != 0;
      if ($urandom_range(0, 7) == 0) digitos = 16'($urandom);
      if ($urandom_range(0, 15) == 0) digitos = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) digitos = 16'h0000;
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) blank_mask = 4'h0;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
